// File: rtl/button_conditioner.sv
// Push-button conditioner: sync, debounce, press/release pulses, auto-repeat.
// In: clk, rst (async active-low), btn_raw. Out: btn_level, btn_press, btn_release, btn_held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_held
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST =
    CNT_W'(REPEAT_PERIOD - 1);
  localparam logic REP_ON = (REPEAT_EN != 0);

  logic s1, s2;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  state_t state, state_n;
  logic flip, rise, fall;
  logic press_n, release_n, held_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Edges are taken from the debounce update itself so the
  // pulses line up with the btn_level transition.
  assign flip = (s2 != btn_level) && (dcnt == DB_LAST);
  assign rise = flip & s2;
  assign fall = flip & ~s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt      <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      dcnt <= '0;
    end else if (flip) begin
      dcnt      <= '0;
      btn_level <= s2;
    end else begin
      dcnt <= dcnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rcnt        <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_held    <= 1'b0;
    end else begin
      state       <= state_n;
      rcnt        <= rcnt_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_held    <= held_n;
    end
  end

  // A release overrides any timer expiry in the same cycle.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    if (fall) begin
      state_n = IDLE;
      rcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_n = DELAY;
            rcnt_n  = '0;
          end
        end
        DELAY: begin
          if (rcnt == RD_LAST) begin
            state_n = REPEAT;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rcnt + ONE;
          end
        end
        REPEAT: begin
          if (rcnt == RP_LAST) rcnt_n = '0;
          else rcnt_n = rcnt + ONE;
        end
        default: begin
          state_n = IDLE;
          rcnt_n  = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_n   = 1'b0;
    release_n = 1'b0;
    held_n    = btn_held;
    if (fall) begin
      release_n = 1'b1;
      held_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: press_n = rise;
        DELAY: begin
          if (rcnt == RD_LAST) begin
            held_n  = 1'b1;
            press_n = REP_ON;
          end
        end
        REPEAT: begin
          if (rcnt == RP_LAST) press_n = REP_ON;
        end
        default: held_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner.
// Two instances: auto-repeat on and off.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic raw, raw1;
  logic lvl, prs, rel, hld;
  logic lvl1, prs1, rel1, hld1;
  int total;
  int passed;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(raw),
    .btn_level(lvl),
    .btn_press(prs),
    .btn_release(rel),
    .btn_held(hld)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(0),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5),
    .CNT_W(16)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .btn_raw(raw1),
    .btn_level(lvl1),
    .btn_press(prs1),
    .btn_release(rel1),
    .btn_held(hld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    raw  = 1'b0;
    raw1 = 1'b0;
    rst  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    logic [3:0] got;
    logic [3:0] exp;
    rst = 1'b0;
    raw1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      raw = i[0];
      tick();
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== 4'b0000)
        $display("FAIL reset_hold i=%0d got %b exp 0000", i, got);
      else passed++;
    end
    raw = 1'b1;
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      got = {lvl, prs, rel, hld};
      exp = {e >= 6, e == 6, 1'b0, 1'b0};
      total++;
      if (got !== exp)
        $display("FAIL reset_release e=%0d got %b exp %b", e, got, exp);
      else passed++;
    end
    do_reset();
  endtask

  task automatic test_press_hold;
    logic [3:0] got;
    logic [3:0] exp;
    logic p;
    raw = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      p = (e == 6) || (e == 16) || (e == 21) ||
          (e == 26) || (e == 31);
      exp = {(e >= 6) && (e < 35), p, e == 35,
             (e >= 16) && (e < 35)};
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== exp)
        $display("FAIL press_hold e=%0d got %b exp %b", e, got, exp);
      else passed++;
      if (e == 29) raw = 1'b0;
    end
  endtask

  task automatic test_bounce;
    logic [3:0] got;
    logic [0:15] pat;
    pat = 16'b1110_1100_0000_0000;
    for (int e = 1; e <= 16; e++) begin
      raw = pat[e-1];
      tick();
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== 4'b0000)
        $display("FAIL bounce e=%0d got %b exp 0000", e, got);
      else passed++;
    end
    raw = 1'b0;
  endtask

  task automatic test_release_race;
    logic [3:0] got;
    logic [3:0] exp;
    logic p;
    raw = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      p = (e == 6) || (e == 16) || (e == 21);
      exp = {(e >= 6) && (e < 26), p, e == 26,
             (e >= 16) && (e < 26)};
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== exp)
        $display("FAIL release_race e=%0d got %b exp %b", e, got, exp);
      else passed++;
      if (e == 20) raw = 1'b0;
    end
    raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {e >= 6, e == 6, 1'b0, 1'b0};
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== exp)
        $display("FAIL race_idle e=%0d got %b exp %b", e, got, exp);
      else passed++;
    end
    do_reset();
  endtask

  task automatic test_no_repeat;
    logic [3:0] got;
    logic [3:0] exp;
    raw1 = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      exp = {(e >= 6) && (e < 46), e == 6, e == 46,
             (e >= 16) && (e < 46)};
      got = {lvl1, prs1, rel1, hld1};
      total++;
      if (got !== exp)
        $display("FAIL no_repeat e=%0d got %b exp %b", e, got, exp);
      else passed++;
      if (e == 40) raw1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [3:0] got;
    logic [3:0] exp;
    logic p;
    raw = 1'b1;
    repeat (20) tick();
    got = {lvl, prs, rel, hld};
    total++;
    if (got !== 4'b1001)
      $display("FAIL mid_hold_pre got %b exp 1001", got);
    else passed++;
    rst = 1'b0;
    #1;
    got = {lvl, prs, rel, hld};
    total++;
    if (got !== 4'b0000)
      $display("FAIL mid_hold_async got %b exp 0000", got);
    else passed++;
    repeat (2) tick();
    rst = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      p = (e == 6) || (e == 16) || (e == 21);
      exp = {e >= 6, p, 1'b0, e >= 16};
      got = {lvl, prs, rel, hld};
      total++;
      if (got !== exp)
        $display("FAIL mid_hold_restart e=%0d got %b exp %b", e, got, exp);
      else passed++;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    raw  = 1'b0;
    raw1 = 1'b0;
    rst  = 1'b0;
    #2;
    test_reset();
    test_press_hold();
    test_bounce();
    test_release_race();
    test_no_repeat();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
